// File: rtl/text_lcd_pkg.sv
// Shared types, instruction opcodes and DDRAM address-map helpers for the
// HD44780-style text-LCD responder.
package text_lcd_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_BUSY  = 2'd2
   } lcd_state_t;

   localparam logic [7:0] INS_CLEAR = 8'h01;
   localparam logic [7:0] INS_HOME  = 8'h02;
   localparam logic [7:0] INS_ENTRY = 8'h04;
   localparam logic [7:0] INS_DISP  = 8'h08;
   localparam logic [7:0] INS_SHIFT = 8'h10;
   localparam logic [7:0] INS_FUNC  = 8'h20;
   localparam logic [7:0] INS_CGRAM = 8'h40;
   localparam logic [7:0] INS_DDRAM = 8'h80;

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [6:0] LINE0_BASE = 7'h00;
   localparam logic [6:0] LINE1_BASE = 7'h40;
   localparam int         LINE_LEN   = 40;
   localparam int         DDRAM_SIZE = 80;

   function automatic logic addr_valid(input logic [6:0] a, input logic two);
      if (two) begin
         return (a < 7'(LINE_LEN)) ||
                ((a >= LINE1_BASE) && (a < (LINE1_BASE + 7'(LINE_LEN))));
      end else begin
         return a < 7'(DDRAM_SIZE);
      end
   endfunction

   // In two-line mode the second line (0x40..) packs directly after the first.
   function automatic logic [6:0] addr_index(input logic [6:0] a, input logic two);
      if (two && (a >= LINE1_BASE)) begin
         return a - (LINE1_BASE - 7'(LINE_LEN));
      end else begin
         return a;
      end
   endfunction

   function automatic logic [6:0] addr_step(input logic [6:0] a, input logic two,
                                            input logic inc);
      if (two) begin
         if (inc) begin
            if (a == 7'h27)      return LINE1_BASE;
            else if (a == 7'h67) return LINE0_BASE;
            else                 return a + 7'd1;
         end else begin
            if (a == LINE1_BASE)      return 7'h27;
            else if (a == LINE0_BASE) return 7'h67;
            else                      return a - 7'd1;
         end
      end else begin
         if (inc) return (a >= 7'h4F) ? 7'h00 : a + 7'd1;
         else     return ((a == 7'h00) || (a > 7'h4F)) ? 7'h4F : a - 7'd1;
      end
   endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Synchronises lcd_e and the bus bundle, holds the bus while E is high and
// produces a one-cycle strobe on the synchronised falling edge of E.
module lcd_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   output logic       e_level,
   output logic       e_held,
   output logic       strobe,
   output logic       held_rs,
   output logic       held_rw,
   output logic [7:0] held_data
);

   logic [SYNC_STAGES-1:0][10:0] pipe;
   logic                         e_prev;

   // E and the bus share one chain so they arrive with identical delay.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe <= '0;
      end else begin
         pipe[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign e_level = pipe[SYNC_STAGES-1][10];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_prev    <= 1'b0;
         held_rs   <= 1'b0;
         held_rw   <= 1'b0;
         held_data <= 8'h00;
      end else begin
         e_prev <= e_level;
         if (e_level) begin
            held_rs   <= pipe[SYNC_STAGES-1][9];
            held_rw   <= pipe[SYNC_STAGES-1][8];
            held_data <= pipe[SYNC_STAGES-1][7:0];
         end
      end
   end

   // e_held: E has been high long enough that the held bus is current.
   assign e_held = e_prev & e_level;
   assign strobe = e_prev & ~e_level;

endmodule

// File: rtl/text_lcd_responder.sv
// Synthesizable HD44780-style text-LCD model: decodes bus transactions,
// keeps an 80-character DDRAM, address counter, busy flag and control flags.
module text_lcd_responder
   import text_lcd_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int BUSY_CYCLES  = 4,
   parameter int CLEAR_CYCLES = 80
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   output logic [7:0] lcd_dout,
   output logic       lcd_dout_en,
   input  logic [6:0] rd_idx,
   output logic [7:0] rd_char,
   output logic [6:0] ac,
   output logic       busy,
   output logic       disp_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       two_line,
   output logic       inc_mode,
   output logic       err_addr,
   output logic       overrun
);

   localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   logic          e_level, e_held, strobe, held_rs, held_rw;
   logic [7:0]    held_data;
   lcd_state_t    state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [6:0]    ac_next;
   logic          disp_next, cursor_next, blink_next, two_next, inc_next;
   logic          err_next, ovr_next;
   logic          we;
   logic [6:0]    widx, aidx;
   logic [7:0]    wdata, ddram_q;
   logic [7:0]    mem [0:DDRAM_SIZE-1];

   lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_data  (lcd_data),
      .e_level   (e_level),
      .e_held    (e_held),
      .strobe    (strobe),
      .held_rs   (held_rs),
      .held_rw   (held_rw),
      .held_data (held_data)
   );

   // Next-state, register updates and DDRAM write request.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      ac_next     = ac;
      disp_next   = disp_on;
      cursor_next = cursor_on;
      blink_next  = blink_on;
      two_next    = two_line;
      inc_next    = inc_mode;
      err_next    = err_addr;
      ovr_next    = overrun;
      we          = 1'b0;
      widx        = 7'd0;
      wdata       = CHAR_SPACE;
      case (state)
         ST_CLEAR: begin
            if (cnt < CW'(DDRAM_SIZE)) begin
               we   = 1'b1;
               widx = cnt[6:0];
            end else begin
               we   = 1'b0;
            end
            if (cnt == CW'(CLEAR_CYCLES - 1)) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt + CW'(1);
            end
            if (strobe && (!held_rw || held_rs)) ovr_next = 1'b1;
            else                                 ovr_next = overrun;
         end
         ST_BUSY: begin
            if (cnt == CW'(BUSY_CYCLES - 1)) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt + CW'(1);
            end
            if (strobe && (!held_rw || held_rs)) ovr_next = 1'b1;
            else                                 ovr_next = overrun;
         end
         ST_IDLE: begin
            if (strobe && !held_rw && held_rs) begin
               widx       = addr_index(ac, two_line);
               we         = (widx < 7'(DDRAM_SIZE));
               wdata      = held_data;
               ac_next    = addr_step(ac, two_line, inc_mode);
               state_next = ST_BUSY;
               cnt_next   = '0;
            end else if (strobe && !held_rw) begin
               state_next = ST_BUSY;
               cnt_next   = '0;
               // Highest set bit selects the instruction.
               if (|(held_data & INS_DDRAM)) begin
                  if (addr_valid(held_data[6:0], two_line)) begin
                     ac_next  = held_data[6:0];
                  end else begin
                     ac_next  = 7'h00;
                     err_next = 1'b1;
                  end
               end else if (|(held_data & INS_CGRAM)) begin
                  ac_next = ac;
               end else if (|(held_data & INS_FUNC)) begin
                  two_next = held_data[3];
               end else if (|(held_data & INS_SHIFT)) begin
                  if (!held_data[3]) ac_next = addr_step(ac, two_line, held_data[2]);
                  else               ac_next = ac;
               end else if (|(held_data & INS_DISP)) begin
                  disp_next   = held_data[2];
                  cursor_next = held_data[1];
                  blink_next  = held_data[0];
               end else if (|(held_data & INS_ENTRY)) begin
                  inc_next = held_data[1];
               end else if (|(held_data & INS_HOME)) begin
                  ac_next = 7'h00;
               end else if (|(held_data & INS_CLEAR)) begin
                  ac_next    = 7'h00;
                  inc_next   = 1'b1;
                  state_next = ST_CLEAR;
               end else begin
                  ac_next = ac;
               end
            end else if (strobe && held_rs) begin
               ac_next    = addr_step(ac, two_line, inc_mode);
               state_next = ST_BUSY;
               cnt_next   = '0;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_CLEAR;
            cnt_next   = '0;
         end
      endcase
   end

   // Control state and architectural registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_CLEAR;
         cnt       <= '0;
         ac        <= 7'h00;
         busy      <= 1'b1;
         disp_on   <= 1'b0;
         cursor_on <= 1'b0;
         blink_on  <= 1'b0;
         two_line  <= 1'b0;
         inc_mode  <= 1'b1;
         err_addr  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         ac        <= ac_next;
         busy      <= (state_next != ST_IDLE);
         disp_on   <= disp_next;
         cursor_on <= cursor_next;
         blink_on  <= blink_next;
         two_line  <= two_next;
         inc_mode  <= inc_next;
         err_addr  <= err_next;
         overrun   <= ovr_next;
      end
   end

   // DDRAM is not reset; the clear sweep initialises it.
   always_ff @(posedge clk) begin
      if (we) mem[widx] <= wdata;
   end

   assign aidx    = addr_index(ac, two_line);
   assign ddram_q = (aidx < 7'(DDRAM_SIZE)) ? mem[aidx] : CHAR_SPACE;

   // Bus read drive and side readback port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lcd_dout_en <= 1'b0;
         lcd_dout    <= 8'h00;
         rd_char     <= 8'h00;
      end else begin
         lcd_dout_en <= e_held & held_rw;
         if (e_held && held_rw) lcd_dout <= held_rs ? ddram_q : {busy, ac};
         else                   lcd_dout <= 8'h00;
         rd_char <= (rd_idx < 7'(DDRAM_SIZE)) ? mem[rd_idx] : 8'h00;
      end
   end

endmodule

// File: tb/tb_text_lcd_responder.sv
// Self-checking bench for text_lcd_responder: directed scenarios plus a
// randomized transaction phase checked against a linear-position model.
module tb_text_lcd_responder;

   localparam int BUSY_CYCLES  = 4;
   localparam int CLEAR_CYCLES = 80;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
   logic [7:0] lcd_data = 8'h00;
   logic [6:0] rd_idx = 7'd0;
   logic [7:0] lcd_dout, rd_char;
   logic       lcd_dout_en;
   logic [6:0] ac;
   logic       busy, disp_on, cursor_on, blink_on, two_line, inc_mode, err_addr, overrun;

   always #5 clk = ~clk;

   text_lcd_responder #(.SYNC_STAGES(2), .BUSY_CYCLES(BUSY_CYCLES),
                        .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
      .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_data(lcd_data), .lcd_dout(lcd_dout), .lcd_dout_en(lcd_dout_en),
      .rd_idx(rd_idx), .rd_char(rd_char), .ac(ac), .busy(busy),
      .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
      .two_line(two_line), .inc_mode(inc_mode), .err_addr(err_addr),
      .overrun(overrun)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: DDRAM as a linear 80-entry array.
   logic [7:0] m_mem [80];
   int m_ac = 0;
   bit m_two = 0, m_inc = 1, m_d = 0, m_c = 0, m_b = 0, m_err = 0, m_ovr = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_valid(input int a);
      if (m_two) return (a < 40) || (a >= 64 && a < 104);
      return a < 80;
   endfunction

   function automatic int m_index(input int a);
      if (m_two && a >= 64) return 40 + (a - 64);
      return a;
   endfunction

   function automatic int m_next(input int a, input bit inc);
      int p;
      p = (m_index(a) + (inc ? 1 : 79)) % 80;
      if (!m_two) return p;
      return (p < 40) ? p : 64 + (p - 40);
   endfunction

   task automatic model_instr(input int v);
      if (v >= 128) begin
         if (m_valid(v - 128)) m_ac = v - 128;
         else begin m_ac = 0; m_err = 1; end
      end else if (v >= 64) begin
         m_ac = m_ac;
      end else if (v >= 32) begin
         m_two = bit'((v >> 3) & 1);
      end else if (v >= 16) begin
         if (((v >> 3) & 1) == 0) m_ac = m_next(m_ac, bit'((v >> 2) & 1));
      end else if (v >= 8) begin
         m_d = bit'((v >> 2) & 1); m_c = bit'((v >> 1) & 1); m_b = bit'(v & 1);
      end else if (v >= 4) begin
         m_inc = bit'((v >> 1) & 1);
      end else if (v >= 2) begin
         m_ac = 0;
      end else if (v == 1) begin
         m_ac = 0; m_inc = 1;
         for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
      end
   endtask

   task automatic bus_cycle(input bit rs, input bit rw, input logic [7:0] d,
                            output logic [7:0] dout, output logic den);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      dout = lcd_dout; den = lcd_dout_en;
      @(negedge clk);
      lcd_e = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_idle_timeout"}, (n < 300) ? 1 : 0, 1);
   endtask

   task automatic write_instr(input logic [7:0] d);
      logic [7:0] dv; logic de;
      bus_cycle(1'b0, 1'b0, d, dv, de);
      model_instr(int'(d));
      wait_idle("instr");
   endtask

   task automatic write_data(input logic [7:0] d);
      logic [7:0] dv; logic de;
      bus_cycle(1'b1, 1'b0, d, dv, de);
      m_mem[m_index(m_ac)] = d;
      m_ac = m_next(m_ac, m_inc);
      wait_idle("data");
   endtask

   task automatic read_bf(input string tag);
      logic [7:0] dv; logic de;
      bus_cycle(1'b0, 1'b1, 8'h00, dv, de);
      check({tag, "_bf"}, dv, {1'b0, 7'(m_ac)});
      check({tag, "_en"}, de, 1);
      check({tag, "_en_drop"}, lcd_dout_en, 0);
   endtask

   task automatic read_data(input string tag);
      logic [7:0] dv; logic de;
      bus_cycle(1'b1, 1'b1, 8'h00, dv, de);
      check({tag, "_data"}, dv, m_mem[m_index(m_ac)]);
      m_ac = m_next(m_ac, m_inc);
      check({tag, "_ac"}, ac, m_ac);
      wait_idle(tag);
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_flags"},
            {ac, two_line, inc_mode, disp_on, cursor_on, blink_on, err_addr, overrun},
            {7'(m_ac), m_two, m_inc, m_d, m_c, m_b, m_err, m_ovr});
   endtask

   task automatic check_char(input int idx);
      @(negedge clk);
      rd_idx = 7'(idx);
      @(posedge clk); #1;
      check($sformatf("char%0d", idx), rd_char, m_mem[idx]);
   endtask

   initial begin
      int n;
      logic [7:0] dv, d;
      logic de;
      logic [7:0] hello [5];
      hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      check("rst_vals",
            {busy, ac, disp_on, cursor_on, blink_on, two_line, inc_mode, err_addr, overrun,
             lcd_dout, lcd_dout_en, rd_char},
            {1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00});

      // Reset again 3 cycles into the sweep, then time the sweep.
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      #1;
      check("midsweep_busy", busy, 1);
      check("midsweep_ac", ac, 0);
      @(negedge clk) rst = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (busy !== 1'b0 && n < 300);
      check("sweep_len", n, CLEAR_CYCLES);
      for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
      for (int i = 0; i < 80; i += 7) check_char(i);
      check_char(79);

      // Initialisation sequence.
      write_instr(8'h38);
      write_instr(8'h0C);
      write_instr(8'h06);
      check("init_flags", {two_line, disp_on, cursor_on, blink_on, inc_mode, overrun},
            6'b110010);
      check_flags("init");

      // "HELLO" at address 3.
      write_instr(8'h83);
      for (int i = 0; i < 5; i++) write_data(hello[i]);
      for (int i = 3; i < 8; i++) check_char(i);
      check("hello_ac", ac, 7'h08);

      // Line wrap 0x27 -> 0x40, then invalid address.
      write_instr(8'hA7);
      write_data(8'h41);
      write_data(8'h42);
      check_char(39);
      check_char(40);
      check("wrap_ac", ac, 7'h41);
      write_instr(8'hA8);
      check("bad_addr", {err_addr, ac}, {1'b1, 7'h00});
      check_flags("bad_addr");

      // Data write landing while busy after 0x80 is dropped.
      @(negedge clk);
      lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h80; lcd_e = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk) lcd_e = 1'b0;
      model_instr(8'h80);
      @(posedge clk);
      @(negedge clk);
      lcd_rs = 1'b1; lcd_data = 8'h5A; lcd_e = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) lcd_e = 1'b0;
      m_ovr = 1;
      wait_idle("overrun");
      check("overrun_set", overrun, 1);
      check_flags("overrun");
      check_char(0);

      // BF read during a clear sweep reports busy.
      bus_cycle(1'b0, 1'b0, 8'h01, dv, de);
      model_instr(1);
      bus_cycle(1'b0, 1'b1, 8'h00, dv, de);
      check("bf_busy_bit", dv[7], 1);
      check("bf_busy_val", dv, 8'h80);
      wait_idle("clear");
      check_flags("clear");
      check_char(3);

      // Write then read back through the bus.
      write_instr(8'hC3);
      write_data(8'h32);
      read_bf("rd_seq");
      check("rd_seq_bf_val", m_ac, 8'h44);
      write_instr(8'hC3);
      read_data("rd_data");
      check("rd_data_ac", ac, 7'h44);

      // Randomized transactions against the model.
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 10))
            0, 1, 2, 3: write_data(8'($urandom_range(32, 126)));
            4: write_instr(8'h80 | 8'($urandom_range(0, 127)));
            5: write_instr(8'h04 | 8'($urandom_range(0, 3)));
            6: write_instr(8'h08 | 8'($urandom_range(0, 7)));
            7: write_instr(8'h10 | 8'($urandom_range(0, 15)));
            8: begin
               write_instr(8'h20 | 8'($urandom_range(0, 31)));
               n = $urandom_range(0, 79);
               if (m_two && n >= 40) n = 64 + (n - 40);
               write_instr(8'h80 | 8'(n));
            end
            9: begin
               if ($urandom_range(0, 1) == 1) read_data($sformatf("rnd_rd%0d", it));
               else read_bf($sformatf("rnd_bf%0d", it));
            end
            default: begin
               if ($urandom_range(0, 3) == 0) write_instr(8'h01);
               else write_instr(8'h02);
            end
         endcase
         check_flags($sformatf("rnd%0d", it));
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      for (int i = 0; i < 80; i++) check_char(i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/text_lcd_responder.md
Name: text_lcd_responder

Overview:
- Receiving end of the HD44780-style 8-bit text-LCD bus that our LCD controller drives: a synthesizable display model.
- Captures E/RS/RW/DATA transactions, decodes the instruction set subset, and maintains an 80-char DDRAM, address counter (AC), busy flag and display-control flags.
- Serves bus reads (BF/AC and DDRAM data) and a side readback port, so the controller can be checked on-board or in simulation without a physical panel.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for lcd_e and the bus bundle (all delayed equally).
- BUSY_CYCLES, 4, busy duration after any accepted non-clear transaction.
- CLEAR_CYCLES, 80, busy duration of clear/reset sweep; must be >= 80.

Ports:
- clk  in  1  system clock, >= 4x lcd_e toggle rate.
- rst  in  1  asynchronous, active-high reset.
- lcd_e  in  1  enable strobe; transaction taken on its falling edge.
- lcd_rs  in  1  0 = instruction/BF, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_data  in  8  write data/instruction.
- lcd_dout  out  8  read data: {busy, ac} (RS=0) or DDRAM[ac] (RS=1).
- lcd_dout_en  out  1  read-drive enable.
- rd_idx  in  7  linear readback index, 0..79.
- rd_char  out  8  DDRAM[rd_idx], 1-cycle latency.
- ac  out  7  address counter.
- busy  out  1  busy flag.
- disp_on, cursor_on, blink_on  out  1 each  display control D/C/B.
- two_line  out  1  function-set N.
- inc_mode  out  1  entry-mode I/D.
- err_addr  out  1  sticky: invalid DDRAM address set.
- overrun  out  1  sticky: write transaction while busy.

Behaviour:
- Reset (async): ac=0, disp_on=cursor_on=blink_on=0, two_line=0, inc_mode=1, err_addr=overrun=0, lcd_dout=0, lcd_dout_en=0, rd_char=0.
  - State goes to CLEAR, sweep counter=0, busy=1. DDRAM is not reset directly; the sweep rewrites it.
  - Reset asserted mid-sweep or mid-transaction restarts the sweep from index 0.
- Capture: lcd_e and {rs,rw,data} pass through SYNC_STAGES flops.
  - While synced E=1, the synced bus is held each cycle.
  - Synced E 1->0 gives a one-cycle strobe; the transaction uses the held values.
  - Bus must be stable over E-high; E-high must be >= 2 clk.
- Reads: while synced E=1 and held rw=1, lcd_dout_en=1 from the next cycle; lcd_dout={busy,ac} or DDRAM[ac].
  - lcd_dout_en drops the cycle after the strobe.
  - BF/AC reads are legal while busy.
  - A data read (RS=1,RW=1) on strobe advances ac; if busy, it is ignored and sets overrun.
- States: CLEAR, IDLE, BUSY.
  - IDLE: strobe with rw=0 executes in 1 cycle, then BUSY for BUSY_CYCLES (clear goes to CLEAR), then IDLE.
  - BUSY/CLEAR: rw=0 strobe is dropped; overrun=1, no state change.
  - CLEAR: writes 0x20 to index 0..79, one per cycle; holds busy for CLEAR_CYCLES total, then IDLE.
- Instruction decode (RS=0, highest set bit wins):
  - 0x01 clear: ac=0, inc_mode=1, enter CLEAR.
  - 0x02/0x03 home: ac=0.
  - 0x04-07: inc_mode=bit1; S is ignored.
  - 0x08-0F: D/C/B = bits 2/1/0.
  - 0x10-1F: if bit3=0, cursor moves by bit2 (1=right) with the wrap rules below; display shift is ignored.
  - 0x20-3F: two_line=bit3.
  - 0x40-7F: CGRAM set, no effect.
  - 0x80-FF: ac=data[6:0] if valid; else ac=0 and err_addr=1.
- Data write (RS=1,RW=0): DDRAM[idx(ac)]=data, then ac advances per inc_mode.
- Address map:
  - one-line: valid 0x00-0x4F, idx=ac; inc 0x4F->0x00, dec 0x00->0x4F.
  - two-line: valid 0x00-0x27 and 0x40-0x67, idx=ac (<0x40) or ac-0x18.
    - inc: 0x27->0x40, 0x67->0x00.
    - dec: 0x40->0x27, 0x00->0x67.
- Simultaneous rd_idx readback and bus write to the same index: rd_char returns the old value.

Decomposition:
- text_lcd_pkg holds:
  - state enum;
  - instruction masks/opcodes (CLEAR 0x01, HOME 0x02, ENTRY 0x04, DISP 0x08, SHIFT 0x10, FUNC 0x20, CGRAM 0x40, DDRAM 0x80);
  - CHAR_SPACE=0x20;
  - line bases 0x00/0x40, LINE_LEN=40, DDRAM_SIZE=80.
- Sub-module lcd_bus_sync: synchronizer chain, held bus, falling-edge strobe and E-high level.

Test Plan:
- Reset 3 cycles into an active sweep -> busy=1, ac=0; busy drops exactly CLEAR_CYCLES later; rd_char=0x20 for idx 0..79.
- Writes 0x38, 0x0C, 0x06 with gaps > BUSY_CYCLES -> two_line=1, disp_on=1, cursor_on=blink_on=0, inc_mode=1, overrun=0.
- 0x83 then 0x48 0x45 0x4C 0x4C 0x4F -> idx3..7 = 48 45 4C 4C 4F, ac=0x08.
- 0xA7, 'A', 'B' -> idx39=0x41, idx40=0x42, ac=0x41; 0xA8 -> err_addr=1, ac=0x00.
- Data write issued 1 cycle after 0x80 accepted -> dropped, overrun=1, DDRAM unchanged; BF read returns lcd_dout[7]=1.
- Read sequence:
  - 0xC3, write 0x32, then BF/AC read after busy -> lcd_dout=0x44.
  - 0xC3, data read -> lcd_dout=0x32, ac=0x44 after strobe.
